// File: rtl/fc_classifier.sv
// Fully-connected classifier behind the 2x2 max-pooling stage: buffers one pooled
// feature map, runs one dot product per class, then reports the argmax class.
module fc_classifier #(
  parameter int NUM_FEAT    = 256,
  parameter int NUM_CLASSES = 4,
  parameter int FEAT_W      = 22,
  parameter int WGT_W       = 8,
  parameter int ACC_W       = 40,
  parameter int ADDR_W      = 10,
  parameter int CLS_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_signal,
  input  logic                     pixel_valid,
  input  logic signed [FEAT_W-1:0] pixel_in,
  output logic [ADDR_W-1:0]        weight_addr,
  input  logic signed [WGT_W-1:0]  weight_data,
  output logic signed [ACC_W-1:0]  score_out,
  output logic                     score_valid,
  output logic [CLS_W-1:0]         class_out,
  output logic                     done_signal,
  output logic                     busy
);

  localparam int K_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int PROD_W = FEAT_W + WGT_W;
  localparam logic [K_W-1:0]   K_LAST = K_W'(NUM_FEAT - 1);
  localparam logic [CLS_W-1:0] C_LAST = CLS_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_FLUSH, S_EMIT, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [K_W-1:0]           r_feat_cnt;
  logic [K_W-1:0]           r_k;
  logic [CLS_W-1:0]         r_cls;
  logic [ADDR_W-1:0]        r_addr;
  logic signed [FEAT_W-1:0] r_buf [NUM_FEAT];
  logic signed [FEAT_W-1:0] r_feat_p1;
  logic                     r_vld_p1;
  logic signed [PROD_W-1:0] w_prod_p1;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_best;

  // Headroom is guaranteed by ACC_W, so widening is a plain sign extension.
  function automatic logic signed [ACC_W-1:0] widen(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_signal) w_next = S_LOAD;
      S_LOAD:  if (pixel_valid && (r_feat_cnt == K_LAST)) w_next = S_MAC;
      S_MAC:   if (r_k == K_LAST) w_next = S_FLUSH;
      S_FLUSH: w_next = S_EMIT;
      S_EMIT:  w_next = (r_cls == C_LAST) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign weight_addr = (r_state == S_MAC) ? r_addr : '0;

  // Feature buffer holds data only; it is fully rewritten every frame.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD) && pixel_valid) r_buf[r_feat_cnt] <= pixel_in;
  end

  // Stage p1: feature travels alongside its weight address, weight arrives next cycle
  always_ff @(posedge clk) begin
    if (r_state == S_MAC) r_feat_p1 <= r_buf[r_k];
  end

  assign w_prod_p1 = r_feat_p1 * weight_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat_cnt  <= '0;
      r_k         <= '0;
      r_cls       <= '0;
      r_addr      <= '0;
      r_vld_p1    <= 1'b0;
      r_acc       <= '0;
      r_best      <= '0;
      score_out   <= '0;
      score_valid <= 1'b0;
      class_out   <= '0;
      done_signal <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      done_signal <= 1'b0;
      r_vld_p1    <= (r_state == S_MAC);

      // Accumulate stage: consumes the pair issued one cycle earlier
      if ((r_state == S_MAC) && (r_k == '0)) r_acc <= '0;
      else if (r_vld_p1)                     r_acc <= r_acc + widen(w_prod_p1);

      case (r_state)
        S_IDLE: begin
          if (start_signal) begin
            r_feat_cnt <= '0;
            r_k        <= '0;
            r_cls      <= '0;
            r_addr     <= '0;
          end
        end
        S_LOAD: begin
          if (pixel_valid) r_feat_cnt <= r_feat_cnt + K_W'(1);
        end
        S_MAC: begin
          r_k    <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end
        S_EMIT: begin
          score_out   <= r_acc;
          score_valid <= 1'b1;
          // Strict compare keeps the lowest index on ties.
          if ((r_cls == '0) || (r_acc > r_best)) begin
            r_best    <= r_acc;
            class_out <= r_cls;
          end
          if (r_cls != C_LAST) r_cls <= r_cls + CLS_W'(1);
        end
        S_DONE: done_signal <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
